sel_input_mux_rom: RTL and testbench

SEL_INPUT_MUX_ROM -- requirements
Module: sel_input_mux_rom

---
 rtl/sel_input_mux_rom_if.sv | 14 +
 rtl/sel_input_mux_rom.sv | 69 ++++++
 tb/tb_sel_input_mux_rom.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sel_input_mux_rom_if.sv
// sel_input_mux_rom_if -- selector-register channel lookup bus.
//   address : channel index (CH_IN_SEL field), driven by the master
//   q       : registered channel descriptor, driven by the ROM (slave)
// Modports: master (requester side), slave (ROM side).
interface sel_input_mux_rom_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 15
);
   logic [AW-1:0] address;
   logic [DW-1:0] q;

   modport master (output address, input  q);
   modport slave  (input  address, output q);
endinterface

// File: rtl/sel_input_mux_rom.sv
// sel_input_mux_rom -- fixed channel-descriptor ROM for the input mux selector.
// Descriptor layout:
//   q[3:0]  mux input address (a2_0..a2_3) = index mod 16
//   q[13:4] one-hot mux enable, bit 4+k drives en2_(k+1), k = index / 16
//   q[14]   entry-valid flag
// Indices >= DEPTH read as all zeros.
// Ports:
//   clock : rising-edge clock for all state
//   rst_  : synchronous active-low reset, clears every register
//   bus   : sel_input_mux_rom_if.slave (address in, q out)
// Build option: define SEL_ROM_OUTREG_EN to add an output register
// (2-cycle read latency instead of 1); table content is unchanged.
module sel_input_mux_rom #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 15,
   parameter int unsigned DEPTH = 157
) (
   input logic                clock,
   input logic                rst_,
   sel_input_mux_rom_if.slave bus
);

   localparam int unsigned EW = DW - 5;   // width of the one-hot enable field

   logic [3:0]    idx;
   logic [AW-5:0] grp;
   logic          valid;
   logic [EW-1:0] en;
   logic [DW-1:0] word;
   logic [DW-1:0] q_reg;

   // The table is a pure function of the index, so it is generated from the
   // index fields rather than stored as a literal list of DEPTH words.
   always_comb begin
      idx   = bus.address[3:0];
      grp   = bus.address[AW-1:4];
      valid = (32'(bus.address) < DEPTH);
      en    = '0;
      for (int unsigned k = 0; k < EW; k++) begin
         en[k] = valid && (32'(grp) == k);
      end
      word = {valid, en, (valid ? idx : 4'h0)};
   end

`ifdef SEL_ROM_OUTREG_EN
   logic [DW-1:0] stage;

   always_ff @(posedge clock) begin
      if (!rst_) begin
         stage <= '0;
         q_reg <= '0;
      end else begin
         stage <= word;
         q_reg <= stage;
      end
   end
`else
   always_ff @(posedge clock) begin
      if (!rst_) begin
         q_reg <= '0;
      end else begin
         q_reg <= word;
      end
   end
`endif

   assign bus.q = q_reg;

endmodule

// File: tb/tb_sel_input_mux_rom.sv
// tb_sel_input_mux_rom -- self-checking bench for sel_input_mux_rom.
// Inputs are driven on the falling edge; q is sampled 1 ns after the rising
// edge and compared with a queue-based reference model of the read pipeline.
module tb_sel_input_mux_rom;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 15;
   localparam int unsigned DEPTH = 157;
`ifdef SEL_ROM_OUTREG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic clock;
   logic rst_;

   sel_input_mux_rom_if #(.AW(AW), .DW(DW)) bus ();

   sel_input_mux_rom #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .rst_  (rst_),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Pipeline model: one entry per outstanding read, oldest at index 0.
   logic [DW-1:0] pipe [$];

   function automatic logic [DW-1:0] rom_ref(input int unsigned a);
      int unsigned v;
      if (a >= DEPTH) return '0;
      v = (1 << 14) + (1 << (4 + a / 16)) + (a % 16);
      return DW'(v);
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare q.
   task automatic step(input int unsigned a, input logic r, input string tag);
      @(negedge clock);
      bus.address = AW'(a);
      rst_        = r;
      @(posedge clock);
      if (!r) begin
         foreach (pipe[i]) pipe[i] = '0;
      end else begin
         pipe.push_back(rom_ref(a));
         void'(pipe.pop_front());
      end
      #1;
      check(tag, bus.q, pipe[0]);
   endtask

   task automatic hold(input int unsigned a, input string tag);
      for (int unsigned i = 0; i < LAT; i++) step(a, 1'b1, tag);
   endtask

   initial begin
      logic [DW-1:0] qs;
      int unsigned   ones;

      for (int unsigned i = 0; i < LAT; i++) pipe.push_back('0);
      bus.address = '0;
      rst_        = 1'b0;

      // Reset held with address 0: q stays clear.
      for (int unsigned i = 0; i < 3; i++) begin
         step(0, 1'b0, "reset");
         check("reset_const", bus.q, 15'h0000);
      end

      // Directed entries after normal latency.
      hold(0, "addr0");
      check("addr0_const", bus.q, 15'h4010);
      hold(17, "addr17");
      check("addr17_const", bus.q, 15'h4021);
      hold(156, "addr156");
      check("addr156_const", bus.q, 15'h600C);
      hold(157, "addr157");
      check("addr157_const", bus.q, 15'h0000);
      hold(255, "addr255");
      check("addr255_const", bus.q, 15'h0000);

      // Back-to-back sweep of every index, one per cycle.
      for (int unsigned a = 0; a < 256; a++) begin
         step(a, 1'b1, "sweep");
         qs   = bus.q;
         ones = $countones(qs[13:4]);
         check("sweep_onehot", DW'(ones), DW'(qs[14] ? 1 : 0));
      end
      for (int unsigned i = 1; i < LAT; i++) step(0, 1'b1, "sweep_drain");

      // Mid-stream reset discards in-flight reads; index 40 = group 2, slot 8.
      hold(40, "pre_rst40");
      step(40, 1'b0, "midrst");
      check("midrst_const", bus.q, 15'h0000);
      hold(40, "post_rst40");
      check("post_rst40_const", bus.q, 15'h4048);

      // Random addresses with occasional single-cycle resets.
      for (int unsigned i = 0; i < 300; i++) begin
         step($urandom_range(0, 255), ($urandom_range(0, 19) != 0), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
